// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multicycle MIPS datapath
//
// Purpose:
//   Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB cycles.
//   Drives the datapath mux selects and enables, and the ALUOp pair that
//   ALU control combines with Funct. Stalls on memory through mem_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode[5:0]         IR[31:26], stable from DECODE onward
//   mem_ready           memory access completes this cycle
//   pc_write            unconditional PC load
//   pc_write_cond       PC load if ALU zero (beq)
//   iord                0=PC addresses memory, 1=ALUOut
//   mem_read/mem_write  memory read / write request
//   ir_write            IR load
//   mem_to_reg          1=MDR to regfile, 0=ALUOut
//   reg_dst             1=rd, 0=rt write address
//   reg_write           regfile write enable
//   alu_src_a           0=PC, 1=A register
//   alu_src_b[1:0]      00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   alu_op1/alu_op0     ALUOp to ALU control
//   pc_source[1:0]      00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op          unrecognised opcode seen in DECODE
//   state[3:0]          current state code (debug)

module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op1,
  output logic       alu_op0,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  state_t     state_q, state_d, state_nxt;
  logic       run_q, run_d;
  logic       pc_write_q, pc_write_d;
  logic       pc_write_cond_q, pc_write_cond_d;
  logic       iord_q, iord_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_dst_q, reg_dst_d;
  logic       reg_write_q, reg_write_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [1:0] pc_source_q, pc_source_d;

  logic       op_lw, op_sw, op_rtype, op_beq, op_j, op_legal;
  logic       fetch_grant;

  assign op_lw    = (opcode == OP_LW);
  assign op_sw    = (opcode == OP_SW);
  assign op_rtype = (opcode == OP_RTYPE);
  assign op_beq   = (opcode == OP_BEQ);
  assign op_j     = (opcode == OP_J);
  assign op_legal = op_lw | op_sw | op_rtype | op_beq | op_j;

  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_lw || op_sw) state_nxt = S_MEMADR;
        else if (op_rtype)  state_nxt = S_EXEC;
        else if (op_beq)    state_nxt = S_BRANCH;
        else if (op_j)      state_nxt = S_JUMP;
        else                state_nxt = S_FETCH;
      end
      S_MEMADR: begin
        if (op_lw)      state_nxt = S_MEMRD;
        else if (op_sw) state_nxt = S_MEMWR;
        else            state_nxt = S_FETCH;
      end
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase

    // The first clock after reset release only arms run_q; FETCH is held
    // so its outputs come up cleanly before the first access can complete.
    state_d = run_q ? state_nxt : S_FETCH;
    run_d   = 1'b1;

    // Moore outputs are decoded from the next state so the registered
    // copies line up with state_q.
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_dst_d       = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 2'b00;
    pc_source_d     = 2'b00;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEMRD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      run_q           <= 1'b0;
      pc_write_q      <= 1'b0;
      pc_write_cond_q <= 1'b0;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      reg_dst_q       <= 1'b0;
      reg_write_q     <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= 2'b00;
      pc_source_q     <= 2'b00;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      pc_write_q      <= pc_write_d;
      pc_write_cond_q <= pc_write_cond_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      reg_dst_q       <= reg_dst_d;
      reg_write_q     <= reg_write_d;
      alu_src_a_q     <= alu_src_a_d;
      alu_src_b_q     <= alu_src_b_d;
      alu_op_q        <= alu_op_d;
      pc_source_q     <= pc_source_d;
    end
  end

  // IR load and PC+4 happen in the same FETCH cycle the memory delivers;
  // gating with run_q keeps them low during and right after reset.
  assign fetch_grant = run_q & (state_q == S_FETCH) & mem_ready;

  assign pc_write      = pc_write_q | fetch_grant;
  assign ir_write      = fetch_grant;
  assign pc_write_cond = pc_write_cond_q;
  assign iord          = iord_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign reg_dst       = reg_dst_q;
  assign reg_write     = reg_write_q;
  assign alu_src_a     = alu_src_a_q;
  assign alu_src_b     = alu_src_b_q;
  assign alu_op1       = alu_op_q[1];
  assign alu_op0       = alu_op_q[0];
  assign pc_source     = pc_source_q;
  assign illegal_op    = (state_q == S_DECODE) & ~op_legal;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed self-checking bench for mips_multicycle_control

module tb_mips_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_op1, alu_op0, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1),
    .alu_op0(alu_op0), .pc_source(pc_source), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector, MSB first:
  // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg reg_dst
  // reg_write alu_src_a alu_src_b[1:0] alu_op1 alu_op0 pc_source[1:0] illegal_op
  logic [16:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 alu_op1, alu_op0, pc_source, illegal_op};

  localparam logic [16:0] PCW   = 17'h10000;
  localparam logic [16:0] PWC   = 17'h08000;
  localparam logic [16:0] IORD  = 17'h04000;
  localparam logic [16:0] MRD   = 17'h02000;
  localparam logic [16:0] MWR   = 17'h01000;
  localparam logic [16:0] IRW   = 17'h00800;
  localparam logic [16:0] MTOR  = 17'h00400;
  localparam logic [16:0] RDST  = 17'h00200;
  localparam logic [16:0] REGW  = 17'h00100;
  localparam logic [16:0] SRCA  = 17'h00080;
  localparam logic [16:0] SB_4  = 17'h00020;
  localparam logic [16:0] SB_IM = 17'h00040;
  localparam logic [16:0] SB_SH = 17'h00060;
  localparam logic [16:0] AOP1  = 17'h00010;
  localparam logic [16:0] AOP0  = 17'h00008;
  localparam logic [16:0] PS_01 = 17'h00002;
  localparam logic [16:0] PS_10 = 17'h00004;
  localparam logic [16:0] ILL   = 17'h00001;

  localparam logic [16:0] E_FETCH  = MRD | SB_4;
  localparam logic [16:0] E_FGO    = MRD | SB_4 | PCW | IRW;
  localparam logic [16:0] E_DEC    = SB_SH;
  localparam logic [16:0] E_MEMADR = SRCA | SB_IM;
  localparam logic [16:0] E_MEMRD  = MRD | IORD;
  localparam logic [16:0] E_MEMWB  = REGW | MTOR;
  localparam logic [16:0] E_MEMWR  = MWR | IORD;
  localparam logic [16:0] E_EXEC   = SRCA | AOP1;
  localparam logic [16:0] E_ALUWB  = REGW | RDST;
  localparam logic [16:0] E_BRANCH = SRCA | AOP0 | PWC | PS_01;
  localparam logic [16:0] E_JUMP   = PCW | PS_10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs for the current cycle, check state and outputs, then advance.
  task automatic cyc(input string tag, input logic mr, input logic [5:0] op,
                     input logic [3:0] es, input logic [16:0] eo);
    mem_ready = mr;
    opcode    = op;
    #1;
    check({tag, " state"}, 32'(state), 32'(es));
    check({tag, " outs"}, 32'(outs), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    #3;
    check("reset state", 32'(state), 32'd0);
    check("reset outs", 32'(outs), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset held outs", 32'(outs), 32'd0);
    check("reset held state", 32'(state), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type: 0,1,6,7,0 ; mem_ready low in DECODE/EXEC must be ignored
    cyc("r fetch",  1'b1, 6'h00, 4'd0, E_FGO);
    cyc("r decode", 1'b0, 6'h00, 4'd1, E_DEC);
    cyc("r exec",   1'b0, 6'h00, 4'd6, E_EXEC);
    cyc("r aluwb",  1'b1, 6'h00, 4'd7, E_ALUWB);

    // lw with two wait cycles in MEMRD
    cyc("lw fetch",  1'b1, 6'h00, 4'd0, E_FGO);
    cyc("lw decode", 1'b1, 6'h23, 4'd1, E_DEC);
    cyc("lw memadr", 1'b1, 6'h23, 4'd2, E_MEMADR);
    cyc("lw memrd0", 1'b0, 6'h23, 4'd3, E_MEMRD);
    cyc("lw memrd1", 1'b0, 6'h23, 4'd3, E_MEMRD);
    cyc("lw memrd2", 1'b1, 6'h23, 4'd3, E_MEMRD);
    cyc("lw memwb",  1'b1, 6'h23, 4'd4, E_MEMWB);

    // sw then beq
    cyc("sw fetch",  1'b1, 6'h23, 4'd0, E_FGO);
    cyc("sw decode", 1'b1, 6'h2B, 4'd1, E_DEC);
    cyc("sw memadr", 1'b1, 6'h2B, 4'd2, E_MEMADR);
    cyc("sw memwr",  1'b1, 6'h2B, 4'd5, E_MEMWR);
    cyc("beq fetch", 1'b1, 6'h2B, 4'd0, E_FGO);
    cyc("beq decode",1'b1, 6'h04, 4'd1, E_DEC);
    cyc("beq branch",1'b1, 6'h04, 4'd8, E_BRANCH);

    // Fetch stall for three cycles, then j
    cyc("stall0",    1'b0, 6'h04, 4'd0, E_FETCH);
    cyc("stall1",    1'b0, 6'h04, 4'd0, E_FETCH);
    cyc("stall2",    1'b0, 6'h04, 4'd0, E_FETCH);
    cyc("j fetch",   1'b1, 6'h04, 4'd0, E_FGO);
    cyc("j decode",  1'b1, 6'h02, 4'd1, E_DEC);
    cyc("j jump",    1'b1, 6'h02, 4'd9, E_JUMP);

    // Illegal opcode
    cyc("ill fetch", 1'b1, 6'h02, 4'd0, E_FGO);
    cyc("ill decode",1'b1, 6'h3F, 4'd1, E_DEC | ILL);
    cyc("ill next",  1'b0, 6'h3F, 4'd0, E_FETCH);

    // Reset asserted in EXEC takes effect without a clock edge
    cyc("rst fetch", 1'b1, 6'h00, 4'd0, E_FGO);
    cyc("rst decode",1'b1, 6'h00, 4'd1, E_DEC);
    #1;
    check("rst exec state", 32'(state), 32'd6);
    check("rst exec outs", 32'(outs), 32'(E_EXEC));
    rst_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    check("reset after clk outs", 32'(outs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
